// File: rtl/fsk_zc_demod.sv
// 2FSK zero-crossing demodulator: counts hysteresis-qualified midpoint
// crossings per symbol window and emits one hard bit per window.
module fsk_zc_demod #(
  parameter int DATA_W  = 11,
  parameter int SYM_LEN = 2048,
  parameter int MID     = 512,
  parameter int HYST    = 8,
  parameter int THRESH  = 6,
  parameter int INVERT  = 0,
  parameter int CNT_W   = $clog2(SYM_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [DATA_W-1:0]            din,
  input  logic                         din_vld,
  input  logic                         sync,
  output logic                         bit_out,
  output logic                         bit_vld,
  output logic [CNT_W-1:0]             zc_last,
  output logic [$clog2(SYM_LEN)-1:0]   sym_idx
);

  // Level tracker
  // state   | meaning
  // ST_UNK  | no level seen since reset/sync; first exit is not a crossing
  // ST_LO   | last qualified level was at or below MID-HYST
  // ST_HI   | last qualified level was at or above MID+HYST
  localparam logic [1:0] ST_UNK = 2'd0;
  localparam logic [1:0] ST_LO  = 2'd1;
  localparam logic [1:0] ST_HI  = 2'd2;

  localparam int IDX_W = $clog2(SYM_LEN);

  // One extra bit on the thresholds keeps MID+HYST from wrapping.
  localparam logic [DATA_W:0]  HI_TH    = (DATA_W+1)'(MID + HYST);
  localparam logic [DATA_W:0]  LO_TH    = (DATA_W+1)'(MID - HYST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [31:0]      THR      = 32'(THRESH);
  localparam logic             INV_B    = (INVERT != 0);

  logic [1:0]       lvl, nxt_lvl;
  logic [CNT_W-1:0] zc_cnt, zc_final;
  logic [DATA_W:0]  din_x;
  logic             above, below, xing, last, take;

  assign din_x = {1'b0, din};
  assign above = (din_x >= HI_TH);
  assign below = (din_x <= LO_TH);
  assign last  = (sym_idx == LAST_IDX);
  assign take  = en && din_vld;

  always_comb begin
    nxt_lvl = lvl;
    xing    = 1'b0;
    if (above) begin
      nxt_lvl = ST_HI;
      xing    = (lvl == ST_LO);
    end else if (below) begin
      nxt_lvl = ST_LO;
      xing    = (lvl == ST_HI);
    end
  end

  assign zc_final = (xing && (zc_cnt != CNT_MAX)) ? zc_cnt + CNT_W'(1) : zc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl     <= ST_UNK;
      zc_cnt  <= '0;
      sym_idx <= '0;
      zc_last <= '0;
      bit_out <= 1'b0;
      bit_vld <= 1'b0;
    end else begin
      bit_vld <= 1'b0;
      if (en && sync) begin
        // sync wins over both the sample and any window completion
        lvl     <= ST_UNK;
        zc_cnt  <= '0;
        sym_idx <= '0;
      end else if (take) begin
        lvl <= nxt_lvl;
        if (last) begin
          sym_idx <= '0;
          zc_cnt  <= '0;
          zc_last <= zc_final;
          bit_out <= (32'(zc_final) <= THR) ^ INV_B;
          bit_vld <= 1'b1;
        end else begin
          sym_idx <= sym_idx + IDX_W'(1);
          zc_cnt  <= zc_final;
        end
      end
    end
  end

endmodule
